div_unit: RTL and testbench

- Iterative RV32M divider for DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the ALU.
- Its registered result is one input of the writeback select mux.
- The pipeline stalls on busy and consumes result when done pulses.

---
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 178 +++++++++++++++++
 tb/tb_div_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// Latency: none (wires only).
// Backpressure: the requester must hold off while busy; start is ignored outside IDLE.
//
// Signals: start/op/dividend/divisor/flush are driven by the requester (master);
// busy/done/result come back from the divider (slave).
interface div_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Latency: done in cycle XLEN+2 after accept (cycle 3 for divide-by-zero / signed overflow).
// Backpressure: busy high while working; start ignored until IDLE; flush aborts without done.
//
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start/op/dividend/
// divisor/flush in and busy/done/result out. result holds until the next done pulse.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CALC    = 2'd1,
    S_SPECIAL = 2'd2,
    S_FINISH  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;     // dividend was negative (signed ops only)
  logic            qneg_q, qneg_d;   // quotient must be negated at the end
  logic            spec_q, spec_d;   // result comes from the special-case preset
  logic            done_q, done_d;

  // Request decode, used only on the accept cycle.
  logic            accept;
  logic            sgn_in, dvd_neg_in, dvs_neg_in, ovf_in, special_in;
  logic [XLEN-1:0] dvd_abs_in, dvs_abs_in;

  // Restoring-division step. The shifted partial remainder keeps the bit that
  // falls out of rem_q: with divisors above 2^(XLEN-1) the remainder can itself
  // exceed 2^(XLEN-1), and dropping that bit would corrupt the compare.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  // Sign-corrected finals for the normal path.
  logic [XLEN-1:0] q_fin, rem_fin;

  assign accept     = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign sgn_in     = ~bus.op[0];
  assign dvd_neg_in = sgn_in & bus.dividend[XLEN-1];
  assign dvs_neg_in = sgn_in & bus.divisor[XLEN-1];
  assign dvd_abs_in = dvd_neg_in ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_abs_in = dvs_neg_in ? (~bus.divisor + 1'b1) : bus.divisor;
  assign ovf_in     = sgn_in && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                             && (bus.divisor == {XLEN{1'b1}});
  assign special_in = (bus.divisor == '0) || ovf_in;

  assign rem_sh  = {rem_q, q_q[XLEN-1]};
  // A borrow out of the top bit means rem_sh < divisor.
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign q_fin   = qneg_q ? (~q_q + 1'b1) : q_q;
  assign rem_fin = neg_q ? (~rem_q + 1'b1) : rem_q;

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = special_in ? S_SPECIAL : S_CALC;
      S_CALC:    if (cnt_q == CW'(XLEN-1)) state_d = S_FINISH;
      S_SPECIAL: state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // FSM: outputs.
  always_comb begin
    bus.busy = (state_q != S_IDLE);
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Datapath next-state.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    q_d      = q_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    neg_d    = neg_q;
    qneg_d   = qneg_q;
    spec_d   = spec_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.op;
          q_d    = dvd_abs_in;
          dvs_d  = dvs_abs_in;
          rem_d  = '0;
          cnt_d  = '0;
          neg_d  = dvd_neg_in;
          qneg_d = dvd_neg_in ^ dvs_neg_in;
          spec_d = special_in;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          q_d   = {q_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          q_d   = {q_q[XLEN-2:0], 1'b0};
        end
      end
      S_SPECIAL: begin
        if (dvs_q == '0) begin
          // q_q still holds |dividend|; undo the negation to recover the raw value.
          q_d   = '1;
          rem_d = neg_q ? (~q_q + 1'b1) : q_q;
        end else begin
          q_d   = {1'b1, {(XLEN-1){1'b0}}};
          rem_d = '0;
        end
      end
      S_FINISH: begin
        if (!bus.flush) begin
          if (spec_q) result_d = op_q[1] ? rem_q : q_q;
          else        result_d = op_q[1] ? rem_fin : q_fin;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      qneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      qneg_q   <= qneg_d;
      spec_q   <= spec_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_div_unit;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_FLUSH = 2;
  localparam int EV_RST   = 3;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [31:0] last_res;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      qq = 64'h0000_0000_FFFF_FFFF;
      rr = {32'd0, a};
    end else begin
      if (!op[0]) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      qq = sa / sb;
      rr = sa % sb;
    end
    return op[1] ? rr[31:0] : qq[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 3;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation in the current cycle (cycle 0) and follows it to done,
  // optionally injecting a spurious start, flush or reset at cycle ev_cyc.
  // Returns inside the done cycle (or idle after an abort) without advancing.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int ev_kind, input int ev_cyc, input string tag);
    logic [31:0] exp;
    int          lat;
    bit          fin;
    bit          abort;
    exp   = ref_res(op, a, b);
    lat   = ref_lat(op, a, b);
    fin   = 1'b0;
    abort = (ev_kind == EV_FLUSH) || (ev_kind == EV_RST);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    for (int k = 1; k <= 45; k++) begin
      if (abort) begin
        if (k <= ev_cyc) begin
          chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
          chk({tag, "/done_early"}, 32'(bus.done), 32'd0);
        end else if (k == ev_cyc + 1) begin
          chk({tag, "/abort_busy"}, 32'(bus.busy), 32'd0);
          chk({tag, "/abort_done"}, 32'(bus.done), 32'd0);
          if (ev_kind == EV_RST) last_res = 32'd0;
          chk({tag, "/abort_result"}, bus.result, last_res);
        end else begin
          chk({tag, "/no_done"}, 32'(bus.done), 32'd0);
          chk({tag, "/idle"}, 32'(bus.busy), 32'd0);
          if (k == ev_cyc + 3) begin
            fin = 1'b1;
            break;
          end
        end
      end else if (k < lat) begin
        chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "/done_early"}, 32'(bus.done), 32'd0);
      end else begin
        chk({tag, "/done"}, 32'(bus.done), 32'd1);
        chk({tag, "/busy_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "/result"}, bus.result, exp);
        last_res = exp;
        fin = 1'b1;
        break;
      end
      if (k == ev_cyc) begin
        case (ev_kind)
          EV_START: begin
            bus.start    = 1'b1;
            bus.op       = ~op;
            bus.dividend = $urandom;
            bus.divisor  = $urandom | 32'd1;
          end
          EV_FLUSH: bus.flush = 1'b1;
          EV_RST:   rst = 1'b1;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      rst       = 1'b0;
    end
    if (!fin) chk({tag, "/timeout_done"}, 32'(bus.done), 32'd1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    clk          = 1'b0;
    rst          = 1'b1;
    n_cmp        = 0;
    n_err        = 0;
    last_res     = 32'd0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    bus.flush    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic unsigned and signed cases, issued back-to-back.
    do_op(OP_DIVU, 32'd100, 32'd7, EV_NONE, 0, "divu_100_7");
    do_op(OP_REMU, 32'd100, 32'd7, EV_NONE, 0, "remu_100_7");
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, EV_NONE, 0, "div_m7_2");
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, EV_NONE, 0, "rem_m7_2");
    do_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, EV_NONE, 0, "div_7_m2");
    do_op(OP_REM,  32'd7, 32'hFFFF_FFFE, EV_NONE, 0, "rem_7_m2");

    // Divide-by-zero and signed overflow.
    do_op(OP_DIVU, 32'd5, 32'd0, EV_NONE, 0, "divu_by0");
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd0, EV_NONE, 0, "rem_by0");
    do_op(OP_DIV,  32'd0, 32'd0, EV_NONE, 0, "div_0_by0");
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, EV_NONE, 0, "div_ovf");
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, EV_NONE, 0, "rem_ovf");

    // Edge values, including divisors above 2^31.
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, EV_NONE, 0, "divu_max_1");
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, EV_NONE, 0, "remu_max_16");
    do_op(OP_DIVU, 32'd3, 32'd5, EV_NONE, 0, "divu_3_5");
    do_op(OP_REMU, 32'd3, 32'd5, EV_NONE, 0, "remu_3_5");
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, EV_NONE, 0, "divu_big");
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, EV_NONE, 0, "remu_big");
    do_op(OP_DIV,  32'h8000_0000, 32'd1, EV_NONE, 0, "div_min_1");

    // Flow control: ignored start while busy, flush, reset mid-operation.
    do_op(OP_DIV,  32'hFFFF_FF9C, 32'd9, EV_START, 5, "start_while_busy");
    do_op(OP_DIVU, 32'd1000, 32'd3, EV_FLUSH, 10, "flush_c10");
    do_op(OP_DIV,  32'd12345, 32'hFFFF_FFF0, EV_RST, 20, "rst_c20");
    do_op(OP_DIVU, 32'd9, 32'd3, EV_NONE, 0, "divu_9_3");

    // flush in IDLE blocks a start in the same cycle.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = OP_DIVU;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_busy", 32'(bus.busy), 32'd0);
    chk("idle_flush_result", bus.result, last_res);

    // Random operations with occasional idle gaps.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom | 32'h8000_0000;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      do_op(rop, ra, rb, EV_NONE, 0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
